// File: rtl/pixel_pair_serializer_if.sv
// Pair-in / pixel-out signal bundle of the pixel pair serializer.
// The master drives the pair stream and pixel_Ready; the slave (the serializer) drives the pixel stream and flags.
interface pixel_pair_serializer_if;
  logic [7:0]  data_R_Even;
  logic [7:0]  data_G_Even;
  logic [7:0]  data_B_Even;
  logic [7:0]  data_R_Odd;
  logic [7:0]  data_G_Odd;
  logic [7:0]  data_B_Odd;
  logic        horizontal_Pulse;
  logic        vertical_Pulse;
  logic        pixel_Ready;
  logic [7:0]  pixel_R;
  logic [7:0]  pixel_G;
  logic [7:0]  pixel_B;
  logic        pixel_Valid;
  logic [9:0]  pixel_Row;
  logic [10:0] pixel_Column;
  logic        frame_Done;
  logic        overflow_Flag;

  modport master (
    output data_R_Even, data_G_Even, data_B_Even,
    output data_R_Odd, data_G_Odd, data_B_Odd,
    output horizontal_Pulse, vertical_Pulse, pixel_Ready,
    input  pixel_R, pixel_G, pixel_B, pixel_Valid,
    input  pixel_Row, pixel_Column, frame_Done, overflow_Flag
  );

  modport slave (
    input  data_R_Even, data_G_Even, data_B_Even,
    input  data_R_Odd, data_G_Odd, data_B_Odd,
    input  horizontal_Pulse, vertical_Pulse, pixel_Ready,
    output pixel_R, pixel_G, pixel_B, pixel_Valid,
    output pixel_Row, pixel_Column, frame_Done, overflow_Flag
  );
endinterface

// File: rtl/pixel_pair_serializer.sv
// Buffers two-pixel-per-clock RGB pairs in a FIFO and re-emits them one pixel per clock
// with row/column coordinates, frame-done and overflow indications.
//
//   state   | meaning
//   S_EMPTY | nothing presented; pop the next visible pair when one exists
//   S_EVEN  | presenting the even pixel of the held pair
//   S_ODD   | presenting the odd pixel; on handshake pop the next pair back-to-back
module pixel_pair_serializer #(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int FIFO_DEPTH   = 512
) (
  input  logic clk,
  input  logic reset,
  pixel_pair_serializer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [10:0] COL_LAST = 11'(IMAGE_WIDTH - 1);
  localparam logic [9:0]  ROW_LAST = 10'(IMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {S_EMPTY, S_EVEN, S_ODD} state_t;

  state_t        state_q, state_d;
  logic [47:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, wr_addr;
  logic [CW-1:0] count_q;
  logic [CW:0]   occupancy;
  logic          wr_last_q, vsync_q;
  logic [47:0]   pair_q, pair_in;
  logic [23:0]   pix;
  logic [9:0]    row_q;
  logic [10:0]   col_q;
  logic          done_q, ovf_q;
  logic          frame_start, in_flight, full, avail;
  logic          push, drop, pop, wr_en, handshake;

  assign pair_in     = {bus.data_R_Even, bus.data_G_Even, bus.data_B_Even,
                        bus.data_R_Odd, bus.data_G_Odd, bus.data_B_Odd};
  assign frame_start = bus.vertical_Pulse & ~vsync_q;
  assign in_flight   = (state_q != S_EMPTY);
  assign handshake   = in_flight & bus.pixel_Ready;

  // The pair held in the serializer still occupies a slot until its odd pixel retires.
  assign occupancy = {1'b0, count_q} + (CW+1)'(in_flight);
  assign full      = (occupancy >= (CW+1)'(FIFO_DEPTH));
  // A pair becomes poppable one cycle after its write, so the newest entry is excluded.
  assign avail     = (count_q > CW'(wr_last_q));

  assign push    = bus.horizontal_Pulse & ~full & ~frame_start;
  assign drop    = bus.horizontal_Pulse & full & ~frame_start;
  assign wr_en   = frame_start ? bus.horizontal_Pulse : push;
  assign wr_addr = frame_start ? '0 : wr_ptr_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_EMPTY: if (avail) begin
        pop     = 1'b1;
        state_d = S_EVEN;
      end
      S_EVEN: if (handshake) state_d = S_ODD;
      S_ODD: if (handshake) begin
        if (avail) begin
          pop     = 1'b1;
          state_d = S_EVEN;
        end else begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (frame_start) begin
      state_d = S_EMPTY;
      pop     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      vsync_q <= 1'b0;
      pair_q  <= '0;
    end else begin
      state_q <= state_d;
      vsync_q <= bus.vertical_Pulse;
      if (pop) pair_q <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= pair_in;
  end

  // Flush first; a pair arriving on the frame-start cycle lands in the emptied FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_last_q <= 1'b0;
    end else if (frame_start) begin
      wr_ptr_q  <= AW'(bus.horizontal_Pulse);
      rd_ptr_q  <= '0;
      count_q   <= CW'(bus.horizontal_Pulse);
      wr_last_q <= bus.horizontal_Pulse;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q   <= count_q + CW'(push) - CW'(pop);
      wr_last_q <= push;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q  <= '0;
      col_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (frame_start) begin
      row_q  <= '0;
      col_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (drop) ovf_q <= 1'b1;
      if (handshake) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          if (row_q == ROW_LAST) begin
            row_q  <= '0;
            done_q <= 1'b1;
          end else begin
            row_q <= row_q + 10'd1;
          end
        end else begin
          col_q <= col_q + 11'd1;
        end
      end
    end
  end

  assign pix               = (state_q == S_ODD) ? pair_q[23:0] : pair_q[47:24];
  assign bus.pixel_R       = in_flight ? pix[23:16] : 8'h00;
  assign bus.pixel_G       = in_flight ? pix[15:8]  : 8'h00;
  assign bus.pixel_B       = in_flight ? pix[7:0]   : 8'h00;
  assign bus.pixel_Valid   = in_flight;
  assign bus.pixel_Row     = row_q;
  assign bus.pixel_Column  = col_q;
  assign bus.frame_Done    = done_q;
  assign bus.overflow_Flag = ovf_q;
endmodule
